// File: rtl/tsmp_pkg.sv
// ---------------------------------------------------------------------------
// tsmp_pkg
// Shared definitions for the TSMP egress merge path: delimiter position,
// TSMP type codes, EtherType, source indices and the state encodings used
// by the per-source write sides and the output arbiter.
// ---------------------------------------------------------------------------
package tsmp_pkg;

    // Frame delimiter bit of a 9-bit TSMP word (set on head and tail words).
    localparam int TSMP_DELIM_BIT = 8;

    // TSMP type codes carried in the frame header.
    localparam logic [7:0] TSMP_TYPE_READ   = 8'h00;
    localparam logic [7:0] TSMP_TYPE_WRITE  = 8'h01;
    localparam logic [7:0] TSMP_TYPE_CONFIG = 8'h16;
    localparam logic [7:0] TSMP_TYPE_NONE   = 8'hff;

    localparam logic [15:0] TSMP_ETHERTYPE = 16'hff01;

    // Response sources merged toward the MAC.
    localparam int   TSMP_NUM_SRC = 2;
    localparam logic SRC_HCP      = 1'b0;
    localparam logic SRC_PLC      = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_SEND = 2'd1,
        ARB_GAP  = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        WR_OUT     = 2'd0,
        WR_IN      = 2'd1,
        WR_DISCARD = 2'd2
    } wr_state_t;

endpackage

// File: rtl/tsmp_frame_fifo.sv
// ---------------------------------------------------------------------------
// tsmp_frame_fifo
// Per-source frame FIFO. Words of a frame are written at a tentative pointer
// and only become visible to the reader when the tail is written (commit).
// A frame that does not fit is rolled back and the remainder discarded.
//
// Ports
//   i_clk, i_rst      clock, asynchronous active-high reset
//   iv_data/i_data_wr incoming framed word and its valid
//   i_rd_en           pop one committed word; data appears next cycle
//   i_frame_done      reader has consumed a complete frame
//   ov_rd_data        registered read data
//   ov_frame_cnt      number of complete frames held
//   o_drop            one-cycle pulse per dropped frame
// ---------------------------------------------------------------------------
module tsmp_frame_fifo
    import tsmp_pkg::*;
#(
    parameter int DATA_WIDTH = TSMP_DELIM_BIT + 1,
    parameter int FIFO_AW    = 7
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] iv_data,
    input  logic                  i_data_wr,
    input  logic                  i_rd_en,
    input  logic                  i_frame_done,
    output logic [DATA_WIDTH-1:0] ov_rd_data,
    output logic [FIFO_AW:0]      ov_frame_cnt,
    output logic                  o_drop
);

    localparam logic [FIFO_AW:0] DEPTH = {1'b1, {FIFO_AW{1'b0}}};

    logic [DATA_WIDTH-1:0] mem [2**FIFO_AW];
    logic [DATA_WIDTH-1:0] rd_data_reg;

    logic [FIFO_AW:0] wr_ptr_commit_reg, wr_ptr_commit_next;
    logic [FIFO_AW:0] wr_ptr_tent_reg, wr_ptr_tent_next;
    logic [FIFO_AW:0] rd_ptr_reg, rd_ptr_next;
    logic [FIFO_AW:0] frame_cnt_reg, frame_cnt_next;
    wr_state_t        wr_state_reg, wr_state_next;

    logic             is_delim;
    logic             full;
    logic             mem_we;
    logic             commit;
    logic             drop;

    assign is_delim = iv_data[DATA_WIDTH-1];
    // Fill is measured against the tentative pointer so an in-progress frame
    // counts toward occupancy; the extra pointer bit separates full from empty.
    assign full     = ((wr_ptr_tent_reg - rd_ptr_reg) == DEPTH);

    always_comb begin
        wr_state_next    = wr_state_reg;
        wr_ptr_tent_next = wr_ptr_tent_reg;
        mem_we           = 1'b0;
        commit           = 1'b0;
        drop             = 1'b0;
        if (i_data_wr) begin
            case (wr_state_reg)
                WR_OUT: begin
                    if (is_delim) begin
                        if (full) begin
                            // No room even for the head: discard through the tail.
                            drop          = 1'b1;
                            wr_state_next = WR_DISCARD;
                        end else begin
                            mem_we           = 1'b1;
                            wr_ptr_tent_next = wr_ptr_tent_reg + 1'b1;
                            wr_state_next    = WR_IN;
                        end
                    end
                end
                WR_IN: begin
                    if (full) begin
                        drop             = 1'b1;
                        wr_ptr_tent_next = wr_ptr_commit_reg;
                        wr_state_next    = WR_DISCARD;
                    end else begin
                        mem_we           = 1'b1;
                        wr_ptr_tent_next = wr_ptr_tent_reg + 1'b1;
                        if (is_delim) begin
                            commit        = 1'b1;
                            wr_state_next = WR_OUT;
                        end
                    end
                end
                WR_DISCARD: begin
                    if (is_delim) begin
                        wr_state_next = WR_OUT;
                    end
                end
                default: wr_state_next = WR_OUT;
            endcase
        end
    end

    always_comb begin
        wr_ptr_commit_next = commit ? (wr_ptr_tent_reg + 1'b1) : wr_ptr_commit_reg;
        rd_ptr_next        = i_rd_en ? (rd_ptr_reg + 1'b1) : rd_ptr_reg;
        frame_cnt_next     = frame_cnt_reg;
        case ({commit, i_frame_done})
            2'b10:   frame_cnt_next = frame_cnt_reg + 1'b1;
            2'b01:   frame_cnt_next = frame_cnt_reg - 1'b1;
            default: frame_cnt_next = frame_cnt_reg;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_state_reg      <= WR_OUT;
            wr_ptr_commit_reg <= '0;
            wr_ptr_tent_reg   <= '0;
            rd_ptr_reg        <= '0;
            frame_cnt_reg     <= '0;
        end else begin
            wr_state_reg      <= wr_state_next;
            wr_ptr_commit_reg <= wr_ptr_commit_next;
            wr_ptr_tent_reg   <= wr_ptr_tent_next;
            rd_ptr_reg        <= rd_ptr_next;
            frame_cnt_reg     <= frame_cnt_next;
        end
    end

    // Storage with registered read; no reset so it maps onto block RAM.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem[wr_ptr_tent_reg[FIFO_AW-1:0]] <= iv_data;
        end
        if (i_rd_en) begin
            rd_data_reg <= mem[rd_ptr_reg[FIFO_AW-1:0]];
        end
    end

    assign ov_rd_data   = rd_data_reg;
    assign ov_frame_cnt = frame_cnt_reg;
    assign o_drop       = drop;

endmodule

// File: rtl/tsmp_merge.sv
// ---------------------------------------------------------------------------
// tsmp_merge
// Merges TSMP response frames from the HCP and PLC into one framed 9-bit
// stream toward the MAC. Each source has a frame FIFO; a round-robin
// arbiter sends whole committed frames back-to-back with IFG_CYCLES idle
// cycles after each one.
//
// Ports
//   i_clk, i_rst                    clock, asynchronous active-high reset
//   iv_data_hcp / i_data_wr_hcp     HCP response word and valid
//   iv_data_plc / i_data_wr_plc     PLC response word and valid
//   ov_data / o_data_wr             merged word (0 when not valid) and valid
//   ov_drop_cnt_hcp/_plc            overflow drops per source   (stats build)
//   ov_tx_frame_cnt                 frames transmitted          (stats build)
//
// Optional feature: define TSMP_MERGE_STATS_EN to add the saturating
// statistics counters and their ports.
// ---------------------------------------------------------------------------
module tsmp_merge
    import tsmp_pkg::*;
#(
    parameter int DATA_WIDTH = TSMP_DELIM_BIT + 1,
    parameter int FIFO_AW    = 7,
    parameter int IFG_CYCLES = 2,
    parameter int CNT_W      = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] iv_data_hcp,
    input  logic                  i_data_wr_hcp,
    input  logic [DATA_WIDTH-1:0] iv_data_plc,
    input  logic                  i_data_wr_plc,
    output logic [DATA_WIDTH-1:0] ov_data,
    output logic                  o_data_wr
`ifdef TSMP_MERGE_STATS_EN
    ,
    output logic [CNT_W-1:0]      ov_drop_cnt_hcp,
    output logic [CNT_W-1:0]      ov_drop_cnt_plc,
    output logic [CNT_W-1:0]      ov_tx_frame_cnt
`endif
);

    localparam int IFG_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

    logic [DATA_WIDTH-1:0]   src_data  [TSMP_NUM_SRC];
    logic [DATA_WIDTH-1:0]   rd_data   [TSMP_NUM_SRC];
    logic [FIFO_AW:0]        frame_cnt [TSMP_NUM_SRC];
    logic [TSMP_NUM_SRC-1:0] src_wr;
    logic [TSMP_NUM_SRC-1:0] src_avail;
    logic [TSMP_NUM_SRC-1:0] src_drop;
    logic [TSMP_NUM_SRC-1:0] rd_en;
    logic [TSMP_NUM_SRC-1:0] frame_done;

    arb_state_t       state_reg, state_next;
    logic             grant_reg, grant_next;
    logic             last_grant_reg, last_grant_next;
    logic             first_reg, first_next;
    logic             valid_reg;
    logic [IFG_W-1:0] ifg_cnt_reg, ifg_cnt_next;
    logic             pick;
    logic             tx_tail;
    logic [DATA_WIDTH-1:0] out_word;

    assign src_data[SRC_HCP] = iv_data_hcp;
    assign src_data[SRC_PLC] = iv_data_plc;
    assign src_wr[SRC_HCP]   = i_data_wr_hcp;
    assign src_wr[SRC_PLC]   = i_data_wr_plc;

    for (genvar gi = 0; gi < TSMP_NUM_SRC; gi++) begin : g_src
        tsmp_frame_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .FIFO_AW    (FIFO_AW)
        ) u_fifo (
            .i_clk        (i_clk),
            .i_rst        (i_rst),
            .iv_data      (src_data[gi]),
            .i_data_wr    (src_wr[gi]),
            .i_rd_en      (rd_en[gi]),
            .i_frame_done (frame_done[gi]),
            .ov_rd_data   (rd_data[gi]),
            .ov_frame_cnt (frame_cnt[gi]),
            .o_drop       (src_drop[gi])
        );
        assign src_avail[gi] = |frame_cnt[gi];
    end

    // The word on the output this cycle was read from the granted FIFO in the
    // previous cycle; its delimiter (past the head) marks the tail.
    assign out_word = rd_data[grant_reg];

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        first_next      = first_reg;
        ifg_cnt_next    = ifg_cnt_reg;
        rd_en           = '0;
        frame_done      = '0;
        tx_tail         = 1'b0;
        pick            = SRC_HCP;
        case (state_reg)
            ARB_IDLE: begin
                if (src_avail[SRC_HCP] && src_avail[SRC_PLC]) begin
                    pick = ~last_grant_reg;
                end else if (src_avail[SRC_PLC]) begin
                    pick = SRC_PLC;
                end
                if (|src_avail) begin
                    grant_next      = pick;
                    last_grant_next = pick;
                    first_next      = 1'b1;
                    rd_en[pick]     = 1'b1;
                    state_next      = ARB_SEND;
                end
            end
            ARB_SEND: begin
                first_next = 1'b0;
                if (out_word[DATA_WIDTH-1] && !first_reg) begin
                    // Tail is on the output: stop reading and release the frame.
                    frame_done[grant_reg] = 1'b1;
                    tx_tail               = 1'b1;
                    ifg_cnt_next          = '0;
                    state_next            = (IFG_CYCLES == 0) ? ARB_IDLE : ARB_GAP;
                end else begin
                    rd_en[grant_reg] = 1'b1;
                end
            end
            ARB_GAP: begin
                if (ifg_cnt_reg == IFG_W'(IFG_CYCLES - 1)) begin
                    state_next = ARB_IDLE;
                end else begin
                    ifg_cnt_next = ifg_cnt_reg + 1'b1;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg      <= ARB_IDLE;
            grant_reg      <= SRC_HCP;
            // Seeded as if PLC went last so HCP wins the first tie.
            last_grant_reg <= SRC_PLC;
            first_reg      <= 1'b0;
            valid_reg      <= 1'b0;
            ifg_cnt_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
            first_reg      <= first_next;
            valid_reg      <= |rd_en;
            ifg_cnt_reg    <= ifg_cnt_next;
        end
    end

    assign o_data_wr = valid_reg;
    assign ov_data   = valid_reg ? out_word : '0;

`ifdef TSMP_MERGE_STATS_EN
    logic [CNT_W-1:0] tx_cnt_reg;

    for (genvar gi = 0; gi < TSMP_NUM_SRC; gi++) begin : g_drop
        logic [CNT_W-1:0] cnt_reg;
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                cnt_reg <= '0;
            end else if (src_drop[gi] && (cnt_reg != '1)) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tx_cnt_reg <= '0;
        end else if (tx_tail && (tx_cnt_reg != '1)) begin
            tx_cnt_reg <= tx_cnt_reg + 1'b1;
        end
    end

    assign ov_drop_cnt_hcp = g_drop[0].cnt_reg;
    assign ov_drop_cnt_plc = g_drop[1].cnt_reg;
    assign ov_tx_frame_cnt = tx_cnt_reg;
`endif

endmodule
